// File: rtl/sorted_insert.sv
// rtl/sorted_insert.sv - sorted insertion writer for a 32x8 single-port RAM
module sorted_insert #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] value,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_wren,
  output logic              done,
  output logic              rejected,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic [2:0]        state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD    = 3'd1;
  localparam logic [2:0] S_CMP   = 3'd2;
  localparam logic [2:0] S_PLACE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] pos_q, pos_d;
  logic              rej_q, rej_d;
  logic [ADDR_W:0]   count_m1;

  // Topmost occupied address; only used when count is non-zero.
  assign count_m1 = count_q - 1'b1;

  // Next-state and RAM port decode: scan down from the top, shifting larger entries up.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    val_d    = val_q;
    idx_d    = idx_q;
    pos_d    = pos_q;
    rej_d    = rej_q;
    ram_addr = '0;
    ram_din  = '0;
    ram_wren = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (count_q == FULL_COUNT) begin
            rej_d   = 1'b1;
            state_d = S_DONE;
          end else if (count_q == '0) begin
            val_d   = value;
            pos_d   = '0;
            state_d = S_PLACE;
          end else begin
            val_d   = value;
            idx_d   = count_m1[ADDR_W-1:0];
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        ram_addr = idx_q;
        state_d  = S_CMP;
      end
      S_CMP: begin
        if (ram_dout > val_q) begin
          // Larger entry moves up one slot; the write happens in the compare cycle.
          ram_addr = idx_q + 1'b1;
          ram_din  = ram_dout;
          ram_wren = 1'b1;
          if (idx_q == '0) begin
            pos_d   = '0;
            state_d = S_PLACE;
          end else begin
            idx_d   = idx_q - 1'b1;
            state_d = S_RD;
          end
        end else begin
          // Equal entries stop the scan so duplicates land after existing equals.
          pos_d   = idx_q + 1'b1;
          state_d = S_PLACE;
        end
      end
      S_PLACE: begin
        ram_addr = pos_q;
        ram_din  = val_q;
        ram_wren = 1'b1;
        count_d  = count_q + 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (!start) begin
          rej_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset empties the RAM logically by clearing count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      val_q   <= '0;
      idx_q   <= '0;
      pos_q   <= '0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      val_q   <= val_d;
      idx_q   <= idx_d;
      pos_q   <= pos_d;
      rej_q   <= rej_d;
    end
  end

  assign done     = (state_q == S_DONE);
  assign rejected = rej_q;
  assign full     = (count_q == FULL_COUNT);
  assign count    = count_q;
  assign state    = state_q;

endmodule

// File: tb/tb_sorted_insert.sv
// tb/tb_sorted_insert.sv - self-checking bench for sorted_insert
module tb_sorted_insert;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] value = 8'd0;
  logic [7:0] ram_dout = 8'd0;
  logic [4:0] ram_addr;
  logic [7:0] ram_din;
  logic       ram_wren;
  logic       done;
  logic       rejected;
  logic       full;
  logic [5:0] count;
  logic [2:0] state;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] ram_mem [32];
  int q[$];
  int wlog_a[$];
  int wlog_d[$];

  typedef struct {
    logic [7:0] v;
    int         lat;
    int         cnt;
  } vec_t;

  sorted_insert dut (
    .clk(clk), .reset(reset), .start(start), .value(value),
    .ram_dout(ram_dout), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_wren(ram_wren), .done(done), .rejected(rejected), .full(full),
    .count(count), .state(state)
  );

  always #5 clk = ~clk;

  // Single-port RAM with registered read, plus a log of every write seen.
  always @(posedge clk) begin
    if (ram_wren) begin
      ram_mem[ram_addr] <= ram_din;
      wlog_a.push_back(int'(ram_addr));
      wlog_d.push_back(int'(ram_din));
    end else begin
      ram_dout <= ram_mem[ram_addr];
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    q.delete();
  endtask

  // One insert; expectations come from the sorted-list model unless the table supplies them.
  task automatic do_insert(input logic [7:0] v, input int tbl_lat, input int tbl_cnt);
    int n, shifts, pos, m, exp_lat, exp_cnt, lat, nw;
    bit rej;
    int ea[$];
    int ed[$];
    n = q.size();
    rej = (n == 32);
    shifts = 0;
    foreach (q[i]) if (q[i] > int'(v)) shifts++;
    pos = n - shifts;
    m = (shifts == n) ? n : shifts + 1;
    exp_lat = rej ? 1 : 2 + 2 * m;
    exp_cnt = rej ? n : n + 1;
    if (tbl_lat >= 0) exp_lat = tbl_lat;
    if (tbl_cnt >= 0) exp_cnt = tbl_cnt;
    if (!rej) begin
      for (int i = n - 1; i >= pos; i--) begin
        ea.push_back(i + 1);
        ed.push_back(q[i]);
      end
      ea.push_back(pos);
      ed.push_back(int'(v));
    end
    wlog_a.delete();
    wlog_d.delete();
    @(negedge clk);
    value = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    lat = 1;
    value = 8'($urandom);
    while (!done && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("done", int'(done), 1);
    chk("rejected", int'(rejected), int'(rej));
    chk("count", int'(count), exp_cnt);
    chk("full", int'(full), int'(exp_cnt == 32));
    nw = wlog_a.size();
    chk("num_writes", nw, ea.size());
    for (int i = 0; i < nw && i < ea.size(); i++) begin
      chk("write_addr", wlog_a[i], ea[i]);
      chk("write_data", wlog_d[i], ed[i]);
    end
    @(posedge clk);
    #1;
    chk("done_hold", int'(state), 5);
    chk("no_write_in_hold", wlog_a.size(), nw);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("back_idle", int'(state), 0);
    chk("done_clear", int'(done), 0);
    chk("rejected_clear", int'(rejected), 0);
    if (!rej) q.insert(pos, int'(v));
  endtask

  task automatic chk_contents();
    for (int i = 0; i < q.size(); i++) chk("mem_content", int'(ram_mem[i]), q[i]);
  endtask

  initial begin
    vec_t tbl[$];
    int lo, hi, mid;
    bit found;

    // Reset state
    #12;
    chk("rst_state", int'(state), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rejected", int'(rejected), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_wren", int'(ram_wren), 0);
    chk("rst_addr", int'(ram_addr), 0);
    chk("rst_din", int'(ram_din), 0);
    do_reset();

    // First insert into an empty RAM
    do_insert(8'd8, 2, 1);
    chk("mem0_first", int'(ram_mem[0]), 8);

    // Directed table: 3, 20, 10, duplicate 10, then 0 (shifts everything)
    do_reset();
    tbl.push_back('{v: 8'd3,  lat: 2,  cnt: 1});
    tbl.push_back('{v: 8'd20, lat: 4,  cnt: 2});
    tbl.push_back('{v: 8'd10, lat: 6,  cnt: 3});
    tbl.push_back('{v: 8'd10, lat: 6,  cnt: 4});
    tbl.push_back('{v: 8'd0,  lat: 10, cnt: 5});
    for (int i = 0; i < tbl.size(); i++) begin
      do_insert(tbl[i].v, tbl[i].lat, tbl[i].cnt);
      if (i == 2) begin
        chk("tbl_mem0", int'(ram_mem[0]), 3);
        chk("tbl_mem1", int'(ram_mem[1]), 10);
        chk("tbl_mem2", int'(ram_mem[2]), 20);
      end
    end
    chk_contents();

    // Binary search for 0 over the sorted contents
    lo = 0;
    hi = int'(count) - 1;
    found = 1'b0;
    while (lo <= hi) begin
      mid = (lo + hi) / 2;
      if (int'(ram_mem[mid]) == 0) begin
        found = 1'b1;
        break;
      end else if (int'(ram_mem[mid]) < 0) lo = mid + 1;
      else hi = mid - 1;
    end
    chk("bsearch_found0", int'(found), 1);

    // Random fill up to full, then a refused insert
    do_reset();
    while (q.size() < 32) begin
      if ($urandom_range(0, 3) == 0) do_insert(8'($urandom_range(0, 255)), -1, -1);
      else do_insert(8'($urandom_range(0, 40)), -1, -1);
    end
    chk_contents();
    do_insert(8'd5, 1, 32);
    chk("full_after_reject", int'(full), 1);

    // Reset during the second compare of an insert
    do_reset();
    do_insert(8'd5, -1, -1);
    do_insert(8'd9, -1, -1);
    do_insert(8'd12, -1, -1);
    @(negedge clk);
    value = 8'd1;
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
    end
    chk("mid_state_cmp", int'(state), 2);
    chk("mid_shift_wren", int'(ram_wren), 1);
    start = 1'b0;
    reset = 1'b1;
    #1;
    chk("abort_state", int'(state), 0);
    chk("abort_count", int'(count), 0);
    chk("abort_wren", int'(ram_wren), 0);
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    do_insert(8'd7, 2, 1);
    chk("after_abort_mem0", int'(ram_mem[0]), 7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
